aip_host_responder: RTL and testbench
=====================================

Name: aip_host_responder

Overview:
- Slave-side endpoint of the AIP host bus, instantiated inside each coprocessor core such as the convolution coprocessor.
- Decodes conf_dbus/read/write/start from the host and owns the input memory Y, the output memory Z, the CSIZE_Y config register, the STATUS register (interrupt mask and flags) and the IP_ID word.
- Hands the compute core a one-cycle start pulse plus memory ports, and raises the active-low interrupt when the core reports done.

Parameters:
- DATAWIDTH, 32, host data bus width.
- SIZE_Y, 64, depth of input memory Y (words).
- SIZE_Z, 64, depth of output memory Z (words).
- IP_ID_VAL, 32'h1000500B, value returned on an IP_ID read.

Ports:
- clk  in  1  system clock, rising edge.
- rst_a  in  1  asynchronous active-low reset.
- en_s  in  1  synchronous enable; when 0, all host strobes are ignored and state holds.
- data_in  in  DATAWIDTH  host write data.
- data_out  out  DATAWIDTH  registered host read data.
- write  in  1  host write strobe, one access per cycle high.
- read  in  1  host read strobe, one access per cycle high.
- start  in  1  host start strobe.
- conf_dbus  in  5  access selector: 0 MMEM_Y, 1 AMEM_Y, 2 MMEM_Z, 3 AMEM_Z, 4 CSIZE_Y, 5 ASIZE_Y, 30 STATUS, 31 IP_ID.
- int_req  out  1  interrupt request, active-low: 0 = pending.
- core_start  out  1  one-cycle start pulse to the compute core.
- core_done  in  1  one-cycle done pulse from the core.
- core_y_addr  in  $clog2(SIZE_Y)  core read address into memory Y.
- core_y_data  out  DATAWIDTH  Y word, registered, 1-cycle latency.
- core_z_we  in  1  core write enable into memory Z.
- core_z_addr  in  $clog2(SIZE_Z)  core write address into memory Z.
- core_z_data  in  DATAWIDTH  core write data into memory Z.
- conf_size_y  out  DATAWIDTH  CSIZE_Y register contents.

Behaviour:
- Reset (rst_a=0, async): data_out=0, int_req=1, core_start=0, core_y_data=0, conf_size_y=0, all pointers=0, mask=0, flags=0, busy=0. Memory contents are not reset.
- All host accesses are sampled on a rising clk edge with en_s=1.

Write (write=1), by conf_dbus:
- 1 / 3 / 5: load the Y / Z / CSIZE pointer with data_in, truncated to the pointer width.
- 0: Y[ptr_y] <= data_in, then ptr_y++.
- 4: CSIZE_Y <= data_in; the CSIZE pointer is accepted but there is only one register.
- 30: mask <= data_in[23:16]; flags <= flags & ~data_in[7:0] (write-1-to-clear).
- 2, 31 and undefined codes: no effect.

Read (read=1):
- data_out is registered on that edge (1-cycle latency):
  - 2: Z[ptr_z], then ptr_z++.
  - 30: {8'h00, mask, 7'h00, busy, flags}.
  - 31: IP_ID_VAL.
  - Any other code: 0.
- Back-to-back reads stream consecutive Z words, one per cycle.

Pointers:
- Wrap modulo depth: ptr_y=SIZE_Y-1 followed by a write gives ptr_y=0.

Simultaneous and boundary events:
- write and read in the same cycle: the write executes; the read is ignored and data_out holds.
- Host read of Z and core write of Z at the same address in the same cycle: the read returns the old word.

Start/done FSM:
- States IDLE and BUSY.
- IDLE: start=1 -> core_start=1 for exactly one cycle, busy=1, go to BUSY.
- BUSY: start is ignored (no second core_start). core_done=1 -> flags[0]=1, busy=0, go to IDLE.
- core_done in IDLE still sets flags[0].
- core_done and a STATUS clear of bit 0 in the same cycle: the set wins.

Interrupt:
- int_req = ~|(flags & mask), registered, so it updates one cycle after the flag or mask changes.

en_s=0:
- Host strobes are ignored.
- The core ports stay live: Z writes and core_done are still honoured.

Reset mid-operation:
- FSM returns to IDLE; no core_start is generated after reset release unless a new start arrives.

Optional Feature:
- Macro AIP_ERR_FLAG_EN.
- Defined: flags[1] is set on start while BUSY, or on a write/read to an undefined conf_dbus code. It is W1C through STATUS and participates in int_req via mask[1].
- Undefined: flags[1] is always 0; such accesses are silently ignored.

Test Plan:
- Reset, then read 31 and read 30 -> data_out=32'h1000500B, then 32'h00000000; int_req=1.
- Write AMEM_Y=0, write MMEM_Y 25 words 0..24 -> core_y_addr=7 returns core_y_data=7 one cycle later. Write CSIZE_Y=25 -> conf_size_y=25.
- Write STATUS=32'h00010000, pulse start -> core_start high exactly 1 cycle and STATUS reads 32'h00010100. core_done -> int_req=0 one cycle later and STATUS reads 32'h00010001. Write STATUS=32'h00010001 -> int_req=1 and STATUS reads 32'h00010000.
- Core writes Z[i]=i+100 for i=0..63; write AMEM_Z=62, then 4 back-to-back reads -> 162, 163, 100, 101 (pointer wrap).
- en_s=0 with a write to MMEM_Y of 32'hDEAD -> Y unchanged, ptr_y unchanged. Write and read asserted together with conf 0 -> Y written, data_out holds.
- Second start while BUSY -> no extra core_start. With AIP_ERR_FLAG_EN defined: STATUS bit 1 = 1; without it: STATUS bit 1 = 0.

Source files
------------

// File: rtl/aip_host_responder.sv
// AIP host bus slave: Y/Z memories, CSIZE_Y, STATUS, IP_ID, start/done FSM.
// Optional macro AIP_ERR_FLAG_EN enables the error flag in STATUS bit 1.
module aip_host_responder #(
  parameter int          DATAWIDTH = 32,
  parameter int          SIZE_Y    = 64,
  parameter int          SIZE_Z    = 64,
  parameter logic [31:0] IP_ID_VAL = 32'h1000500B
) (
  input  logic                      clk,
  input  logic                      rst_a,
  input  logic                      en_s,
  input  logic [DATAWIDTH-1:0]      data_in,
  output logic [DATAWIDTH-1:0]      data_out,
  input  logic                      write,
  input  logic                      read,
  input  logic                      start,
  input  logic [4:0]                conf_dbus,
  output logic                      int_req,
  output logic                      core_start,
  input  logic                      core_done,
  input  logic [$clog2(SIZE_Y)-1:0] core_y_addr,
  output logic [DATAWIDTH-1:0]      core_y_data,
  input  logic                      core_z_we,
  input  logic [$clog2(SIZE_Z)-1:0] core_z_addr,
  input  logic [DATAWIDTH-1:0]      core_z_data,
  output logic [DATAWIDTH-1:0]      conf_size_y
);

  localparam int AY = $clog2(SIZE_Y);
  localparam int AZ = $clog2(SIZE_Z);

  localparam logic [4:0] C_MMEM_Y = 5'd0;
  localparam logic [4:0] C_AMEM_Y = 5'd1;
  localparam logic [4:0] C_MMEM_Z = 5'd2;
  localparam logic [4:0] C_AMEM_Z = 5'd3;
  localparam logic [4:0] C_CSIZE  = 5'd4;
  localparam logic [4:0] C_ASIZE  = 5'd5;
  localparam logic [4:0] C_STATUS = 5'd30;
  localparam logic [4:0] C_IP_ID  = 5'd31;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  logic [DATAWIDTH-1:0] mem_y [SIZE_Y];
  logic [DATAWIDTH-1:0] mem_z [SIZE_Z];

  state_t               state_q, state_d;
  logic [AY-1:0]        ptr_y_q, ptr_y_d;
  logic [AZ-1:0]        ptr_z_q, ptr_z_d;
  logic [DATAWIDTH-1:0] csize_q, csize_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;
  logic [DATAWIDTH-1:0] ydat_q, ydat_d;
  logic [7:0]           mask_q, mask_d;
  logic [7:0]           flags_q, flags_d;
  logic                 irq_q, irq_d;
  logic                 cstart_q, cstart_d;

  logic                 wr;
  logic                 rd;
  logic                 st;
  logic                 busy;
  logic                 y_we;
  logic [31:0]          status_w;

  function automatic logic [AY-1:0] inc_y(input logic [AY-1:0] p);
    return (p == AY'(SIZE_Y - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AZ-1:0] inc_z(input logic [AZ-1:0] p);
    return (p == AZ'(SIZE_Z - 1)) ? '0 : p + 1'b1;
  endfunction

  // a write wins over a read in the same cycle
  assign wr   = en_s & write;
  assign rd   = en_s & read & ~write;
  assign st   = en_s & start;
  assign busy = (state_q == S_BUSY);
  assign y_we = wr & (conf_dbus == C_MMEM_Y);

  assign status_w = {8'h00, mask_q, 7'h00, busy, flags_q};

`ifdef AIP_ERR_FLAG_EN
  logic code_ok;
  logic err;

  // legal selector codes for host accesses
  always_comb begin
    code_ok = 1'b0;
    unique case (1'b1)
      (conf_dbus <= C_ASIZE): code_ok = 1'b1;
      (conf_dbus >= C_STATUS): code_ok = 1'b1;
      default: code_ok = 1'b0;
    endcase
  end

  assign err = (st & busy) | ((wr | rd) & ~code_ok);
`endif

  // start/done handshake state machine
  always_comb begin
    state_d  = state_q;
    cstart_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (st) begin
          cstart_d = 1'b1;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (core_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // host register decode, pointer update and read data
  always_comb begin
    ptr_y_d = ptr_y_q;
    ptr_z_d = ptr_z_q;
    csize_d = csize_q;
    dout_d  = dout_q;
    mask_d  = mask_q;
    flags_d = flags_q;
    if (wr) begin
      case (conf_dbus)
        C_MMEM_Y: ptr_y_d = inc_y(ptr_y_q);
        C_AMEM_Y: ptr_y_d = data_in[AY-1:0];
        C_AMEM_Z: ptr_z_d = data_in[AZ-1:0];
        C_CSIZE:  csize_d = data_in;
        C_STATUS: begin
          mask_d  = data_in[23:16];
          flags_d = flags_q & ~data_in[7:0];
        end
        default: ;
      endcase
    end
    if (rd) begin
      case (conf_dbus)
        C_MMEM_Z: begin
          dout_d  = mem_z[ptr_z_q];
          ptr_z_d = inc_z(ptr_z_q);
        end
        C_STATUS: dout_d = DATAWIDTH'(status_w);
        C_IP_ID:  dout_d = DATAWIDTH'(IP_ID_VAL);
        default:  dout_d = '0;
      endcase
    end
    if (core_done) begin
      flags_d[0] = 1'b1;
    end
`ifdef AIP_ERR_FLAG_EN
    if (err) begin
      flags_d[1] = 1'b1;
    end
`endif
  end

  // core-side Y read and interrupt, computed from current state
  always_comb begin
    ydat_d = mem_y[core_y_addr];
    irq_d  = ~|(flags_q & mask_q);
  end

  // state registers
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q  <= S_IDLE;
      ptr_y_q  <= '0;
      ptr_z_q  <= '0;
      csize_q  <= '0;
      dout_q   <= '0;
      ydat_q   <= '0;
      mask_q   <= '0;
      flags_q  <= '0;
      irq_q    <= 1'b1;
      cstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_y_q  <= ptr_y_d;
      ptr_z_q  <= ptr_z_d;
      csize_q  <= csize_d;
      dout_q   <= dout_d;
      ydat_q   <= ydat_d;
      mask_q   <= mask_d;
      flags_q  <= flags_d;
      irq_q    <= irq_d;
      cstart_q <= cstart_d;
    end
  end

  // memory arrays, not reset
  always_ff @(posedge clk) begin
    if (y_we) begin
      mem_y[ptr_y_q] <= data_in;
    end
    if (core_z_we) begin
      mem_z[core_z_addr] <= core_z_data;
    end
  end

  assign data_out    = dout_q;
  assign int_req     = irq_q;
  assign core_start  = cstart_q;
  assign core_y_data = ydat_q;
  assign conf_size_y = csize_q;

endmodule

// File: tb/tb_aip_host_responder.sv
// Bench for aip_host_responder: directed plan plus random traffic
// against a behavioural model of the host/core register map.
module tb_aip_host_responder;

  localparam int DW = 32;
  localparam int NY = 64;
  localparam int NZ = 64;
`ifdef AIP_ERR_FLAG_EN
  localparam logic [31:0] ERRB = 32'h2;
`else
  localparam logic [31:0] ERRB = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          rst_a = 1'b0;
  logic          en_s = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    conf_dbus = '0;
  logic          int_req;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [5:0]    core_y_addr = '0;
  logic [DW-1:0] core_y_data;
  logic          core_z_we = 1'b0;
  logic [5:0]    core_z_addr = '0;
  logic [DW-1:0] core_z_data = '0;
  logic [DW-1:0] conf_size_y;

  always #5 clk = ~clk;

  aip_host_responder dut (
    .clk         (clk),
    .rst_a       (rst_a),
    .en_s        (en_s),
    .data_in     (data_in),
    .data_out    (data_out),
    .write       (write),
    .read        (read),
    .start       (start),
    .conf_dbus   (conf_dbus),
    .int_req     (int_req),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_y_addr (core_y_addr),
    .core_y_data (core_y_data),
    .core_z_we   (core_z_we),
    .core_z_addr (core_z_addr),
    .core_z_data (core_z_data),
    .conf_size_y (conf_size_y)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  // behavioural model
  logic [31:0] my [NY];
  logic [31:0] mz [NZ];
  bit          vy [NY];
  bit          vz [NZ];
  int          py = 0;
  int          pz = 0;
  logic [31:0] m_csize = '0;
  logic [31:0] m_dout = '0;
  bit          m_dout_ok = 1'b1;
  logic [31:0] m_ydat = '0;
  bit          m_ydat_ok = 1'b1;
  logic [7:0]  m_mask = '0;
  logic [7:0]  m_flags = '0;
  bit          m_busy = 1'b0;
  bit          m_irq = 1'b1;
  bit          m_cs = 1'b0;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      py = 0; pz = 0; m_csize = '0; m_dout = '0; m_dout_ok = 1'b1;
      m_ydat = '0; m_ydat_ok = 1'b1; m_mask = '0; m_flags = '0;
      m_busy = 1'b0; m_irq = 1'b1; m_cs = 1'b0;
    end else begin
      bit wr, rd, st;
      logic [7:0] nf;
      wr = en_s && write;
      rd = en_s && read && !write;
      st = en_s && start;
      m_irq = ((m_flags & m_mask) == 8'h00);
      m_ydat = my[core_y_addr];
      m_ydat_ok = vy[core_y_addr];
      m_cs = st && !m_busy;
      nf = m_flags;
      if (rd) begin
        m_dout_ok = 1'b1;
        case (conf_dbus)
          5'd2: begin
            m_dout = mz[pz];
            m_dout_ok = vz[pz];
            pz = (pz + 1) % NZ;
          end
          5'd30: m_dout = {8'h00, m_mask, 7'h00, m_busy, m_flags};
          5'd31: m_dout = 32'h1000500B;
          default: m_dout = 32'h0;
        endcase
      end
      if (wr) begin
        case (conf_dbus)
          5'd0: begin
            my[py] = data_in; vy[py] = 1'b1; py = (py + 1) % NY;
          end
          5'd1: py = int'(data_in % NY);
          5'd3: pz = int'(data_in % NZ);
          5'd4: m_csize = data_in;
          5'd30: begin
            m_mask = data_in[23:16];
            nf = m_flags & ~data_in[7:0];
          end
          default: ;
        endcase
      end
      if (core_z_we) begin
        mz[core_z_addr] = core_z_data;
        vz[core_z_addr] = 1'b1;
      end
      if (core_done) nf[0] = 1'b1;
`ifdef AIP_ERR_FLAG_EN
      begin
        bit undef;
        undef = (conf_dbus > 5'd5) && (conf_dbus < 5'd30);
        if ((st && m_busy) || ((wr || rd) && undef)) nf[1] = 1'b1;
      end
`endif
      if (m_busy && core_done) m_busy = 1'b0;
      else if (!m_busy && st) m_busy = 1'b1;
      m_flags = nf;
    end
  end

  // compare every cycle away from the active edge
  always @(negedge clk) begin
    if (m_dout_ok) chk("data_out", data_out, m_dout);
    if (m_ydat_ok) chk("core_y_data", core_y_data, m_ydat);
    chk("int_req", {31'b0, int_req}, {31'b0, m_irq});
    chk("core_start", {31'b0, core_start}, {31'b0, m_cs});
    chk("conf_size_y", conf_size_y, m_csize);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hwr(input logic [4:0] c, input logic [31:0] d);
    write = 1'b1; conf_dbus = c; data_in = d;
    cyc();
    write = 1'b0;
  endtask

  task automatic hrd(input logic [4:0] c);
    read = 1'b1; conf_dbus = c;
    cyc();
    read = 1'b0;
  endtask

  logic [4:0] codes [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd30, 5'd31};

  initial begin
    repeat (2) cyc();
    rst_a = 1'b1;
    cyc();
    chk("rst_dout", data_out, 32'h0);
    chk("rst_irq", {31'b0, int_req}, 32'h1);
    chk("rst_cs", {31'b0, core_start}, 32'h0);
    chk("rst_csize", conf_size_y, 32'h0);

    hrd(5'd31);
    chk("ip_id", data_out, 32'h1000500B);
    hrd(5'd30);
    chk("status0", data_out, 32'h0);

    hwr(5'd1, 32'd0);
    for (int i = 0; i < 25; i++) hwr(5'd0, i);
    core_y_addr = 6'd7;
    cyc();
    chk("y7", core_y_data, 32'd7);
    hwr(5'd4, 32'd25);
    chk("csize", conf_size_y, 32'd25);

    hwr(5'd30, 32'h00010000);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("cs_hi", {31'b0, core_start}, 32'h1);
    cyc();
    chk("cs_lo", {31'b0, core_start}, 32'h0);
    hrd(5'd30);
    chk("st_busy", data_out, 32'h00010100);
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    cyc();
    chk("irq_on", {31'b0, int_req}, 32'h0);
    hrd(5'd30);
    chk("st_done", data_out, 32'h00010001);
    hwr(5'd30, 32'h00010001);
    cyc();
    chk("irq_off", {31'b0, int_req}, 32'h1);
    hrd(5'd30);
    chk("st_clr", data_out, 32'h00010000);

    core_z_we = 1'b1;
    for (int i = 0; i < 64; i++) begin
      core_z_addr = 6'(i);
      core_z_data = 32'(i + 100);
      cyc();
    end
    core_z_we = 1'b0;
    hwr(5'd3, 32'd62);
    read = 1'b1; conf_dbus = 5'd2;
    cyc(); chk("z62", data_out, 32'd162);
    cyc(); chk("z63", data_out, 32'd163);
    cyc(); chk("z0", data_out, 32'd100);
    cyc(); chk("z1", data_out, 32'd101);
    read = 1'b0;

    en_s = 1'b0;
    hwr(5'd0, 32'hDEAD);
    en_s = 1'b1;
    hwr(5'd0, 32'h1234);
    core_y_addr = 6'd25;
    cyc();
    chk("en_off", core_y_data, 32'h1234);
    write = 1'b1; read = 1'b1; conf_dbus = 5'd0; data_in = 32'h77;
    cyc();
    write = 1'b0; read = 1'b0;
    chk("wr_rd_hold", data_out, 32'd101);
    core_y_addr = 6'd26;
    cyc();
    chk("wr_rd_y", core_y_data, 32'h77);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("cs2_hi", {31'b0, core_start}, 32'h1);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("cs2_none", {31'b0, core_start}, 32'h0);
    hrd(5'd30);
    chk("st_err", data_out, 32'h00010100 | ERRB);
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    hwr(5'd30, 32'h000100FF);

    start = 1'b1;
    cyc();
    start = 1'b0;
    rst_a = 1'b0;
    cyc();
    cyc();
    rst_a = 1'b1;
    cyc();
    chk("rst_mid_cs", {31'b0, core_start}, 32'h0);
    cyc();
    chk("rst_mid_cs2", {31'b0, core_start}, 32'h0);
    hrd(5'd30);
    chk("rst_mid_st", data_out, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      en_s = ($urandom_range(0, 9) != 0);
      write = ($urandom_range(0, 3) == 0);
      read = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 15) == 0);
      core_done = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) < 8) conf_dbus = codes[$urandom_range(0, 7)];
      else conf_dbus = 5'($urandom);
      data_in = $urandom;
      core_z_we = ($urandom_range(0, 3) == 0);
      core_z_addr = 6'($urandom);
      core_z_data = $urandom;
      core_y_addr = 6'($urandom);
      cyc();
    end
    en_s = 1'b1; write = 1'b0; read = 1'b0; start = 1'b0;
    core_done = 1'b0; core_z_we = 1'b0;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
